// File: rtl/uart_host_bridge.sv
// uart_host_bridge
//   Bus initiator in front of the UART's MMIO port. Presents the client with a
//   TX byte FIFO that is drained into UART register 0x00 and an RX byte FIFO
//   that is filled by continuously polling UART register 0x04.
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   enable                      1 = issue UART requests, 0 = quiesce
//   clear                       pulse, clears the sticky error flags
//   tx_in_valid/ready/data      client TX byte stream (into the bridge)
//   rx_out_valid/ready/data     client RX byte stream (out of the bridge)
//   u_req_valid/ready/addr/
//   u_req_write/data            UART request port (bridge is initiator)
//   u_resp_valid/data/ready     UART read response port
//   rx_overflow                 sticky: an RX byte was dropped (FIFO full)
//   proto_err                   sticky: response seen with no read outstanding
module uart_host_bridge #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        clear,
  input  logic        tx_in_valid,
  output logic        tx_in_ready,
  input  logic [7:0]  tx_in_data,
  output logic        rx_out_valid,
  input  logic        rx_out_ready,
  output logic [7:0]  rx_out_data,
  output logic        u_req_valid,
  input  logic        u_req_ready,
  output logic [7:0]  u_req_addr,
  output logic        u_req_write,
  output logic [31:0] u_req_data,
  input  logic        u_resp_valid,
  input  logic [31:0] u_resp_data,
  output logic        u_resp_ready,
  output logic        rx_overflow,
  output logic        proto_err
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {S_OFF, S_POLL, S_WRITE} state_t;

  state_t      state_q, state_d;
  logic        req_valid_q, req_write_q, rd_pending_q;
  logic [7:0]  req_addr_q;
  logic [31:0] req_data_q;

  // TX FIFO
  logic [7:0]  tx_mem_q [TX_DEPTH];
  logic [TAW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic        tx_empty, tx_full, tx_push, tx_pop;

  // RX FIFO
  logic [7:0]  rx_mem_q [RX_DEPTH];
  logic [RAW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic        rx_empty, rx_full, rx_push_req, rx_push, rx_pop;

  logic        ovf_q, ovf_d, perr_q, perr_d, ovf_set, perr_set;
  logic        resp_unused;

  assign resp_unused = ^u_resp_data[31:9];

  // Pointers carry one extra wrap bit: equal = empty, only wrap bit differs = full.
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = ((tx_wr_q ^ tx_rd_q) == {1'b1, {TAW{1'b0}}});
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = ((rx_wr_q ^ rx_rd_q) == {1'b1, {RAW{1'b0}}});

  assign tx_in_ready  = resetn & ~tx_full;
  assign tx_push      = tx_in_valid & tx_in_ready;
  // The head byte leaves the FIFO in the cycle it is presented to the UART.
  assign tx_pop       = (state_q == S_WRITE);

  assign rx_out_valid = ~rx_empty;
  assign rx_out_data  = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q[RAW-1:0]];
  assign rx_pop       = rx_out_valid & rx_out_ready;

  // Only a response that follows one of our reads may carry an RX byte.
  assign rx_push_req  = u_resp_valid & rd_pending_q & u_resp_data[8];
  // A full FIFO still takes the byte when a slot is freed in the same cycle.
  assign rx_push      = rx_push_req & (~rx_full | rx_pop);
  assign ovf_set      = rx_push_req & rx_full & ~rx_pop;
  assign perr_set     = u_resp_valid & ~rd_pending_q;

  assign ovf_d  = ovf_set  | (ovf_q  & ~clear);
  assign perr_d = perr_set | (perr_q & ~clear);

  assign tx_wr_d = tx_wr_q + {{TAW{1'b0}}, tx_push};
  assign tx_rd_d = tx_rd_q + {{TAW{1'b0}}, tx_pop};
  assign rx_wr_d = rx_wr_q + {{RAW{1'b0}}, rx_push};
  assign rx_rd_d = rx_rd_q + {{RAW{1'b0}}, rx_pop};

  assign u_req_valid  = req_valid_q;
  assign u_req_addr   = req_addr_q;
  assign u_req_write  = req_write_q;
  assign u_req_data   = req_data_q;
  assign u_resp_ready = resetn;
  assign rx_overflow  = ovf_q;
  assign proto_err    = perr_q;

  // A WRITE always lasts exactly one cycle, even if enable drops meanwhile.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_OFF:   state_d = enable ? S_POLL : S_OFF;
      S_POLL: begin
        if (!enable)                     state_d = S_OFF;
        else if (!tx_empty && u_req_ready) state_d = S_WRITE;
        else                             state_d = S_POLL;
      end
      S_WRITE: state_d = enable ? S_POLL : S_OFF;
      default: state_d = S_OFF;
    endcase
  end

  // Request outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_OFF;
      req_valid_q  <= 1'b0;
      req_write_q  <= 1'b0;
      req_addr_q   <= 8'h00;
      req_data_q   <= 32'd0;
      rd_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_valid_q  <= (state_d != S_OFF);
      req_write_q  <= (state_d == S_WRITE);
      req_addr_q   <= (state_d == S_POLL) ? 8'h04 : 8'h00;
      req_data_q   <= (state_d == S_WRITE) ? {24'd0, tx_mem_q[tx_rd_q[TAW-1:0]]} : 32'd0;
      rd_pending_q <= (state_q == S_POLL);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
      rx_wr_q <= rx_wr_d;
      rx_rd_q <= rx_rd_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
    end
  end

  // FIFO storage is data only and needs no reset.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q[TAW-1:0]] <= tx_in_data;
    if (rx_push) rx_mem_q[rx_wr_q[RAW-1:0]] <= u_resp_data[7:0];
  end

endmodule

// File: tb/tb_uart_host_bridge.sv
module tb_uart_host_bridge;
  localparam int TX_DEPTH = 8;
  localparam int RX_DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn, enable, clear;
  logic        tx_in_valid, tx_in_ready;
  logic [7:0]  tx_in_data;
  logic        rx_out_valid, rx_out_ready;
  logic [7:0]  rx_out_data;
  logic        u_req_valid, u_req_ready, u_req_write;
  logic [7:0]  u_req_addr;
  logic [31:0] u_req_data;
  logic        u_resp_valid, u_resp_ready;
  logic [31:0] u_resp_data;
  logic        rx_overflow, proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_host_bridge #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
    .tx_in_valid(tx_in_valid), .tx_in_ready(tx_in_ready), .tx_in_data(tx_in_data),
    .rx_out_valid(rx_out_valid), .rx_out_ready(rx_out_ready), .rx_out_data(rx_out_data),
    .u_req_valid(u_req_valid), .u_req_ready(u_req_ready), .u_req_addr(u_req_addr),
    .u_req_write(u_req_write), .u_req_data(u_req_data),
    .u_resp_valid(u_resp_valid), .u_resp_data(u_resp_data), .u_resp_ready(u_resp_ready),
    .rx_overflow(rx_overflow), .proto_err(proto_err)
  );

  // {valid, write, addr, data, resp_ready, tx_ready, rx_valid, rx_data, ovf, perr}
  logic [54:0] dut_pack;
  assign dut_pack = {u_req_valid, u_req_write, u_req_addr, u_req_data, u_resp_ready,
                     tx_in_ready, rx_out_valid, rx_out_data, rx_overflow, proto_err};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // mode: 0 idle, 1 polling, 2 writing the TX head byte
  int         m_mode = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit         m_read_last = 0, m_ovf = 0, m_perr = 0;
  bit         mdl_on = 0;

  always @(posedge clk) begin : model
    bit rpop, tpush, bpush, pset, oset, tx_nonempty;
    int nmode;
    if (!resetn) begin
      m_mode = 0; txq.delete(); rxq.delete();
      m_read_last = 0; m_ovf = 0; m_perr = 0;
    end else begin
      tx_nonempty = (txq.size() > 0);
      rpop  = (rxq.size() > 0) && rx_out_ready;
      tpush = tx_in_valid && (txq.size() < TX_DEPTH);
      pset  = u_resp_valid && !m_read_last;
      bpush = u_resp_valid && m_read_last && u_resp_data[8];
      oset  = 0;
      if (rpop) void'(rxq.pop_front());
      if (bpush) begin
        if (rxq.size() < RX_DEPTH) rxq.push_back(u_resp_data[7:0]);
        else oset = 1;
      end
      if (m_mode == 2) void'(txq.pop_front());
      if (tpush) txq.push_back(tx_in_data);
      m_ovf  = oset || (m_ovf && !clear);
      m_perr = pset || (m_perr && !clear);
      if (!enable) nmode = 0;
      else if (m_mode == 1 && tx_nonempty && u_req_ready) nmode = 2;
      else nmode = 1;
      m_read_last = (m_mode == 1);
      m_mode = nmode;
    end
  end

  function automatic logic [54:0] mdl_out();
    logic [7:0] addr, wd, rd;
    addr = (m_mode == 1) ? 8'h04 : 8'h00;
    wd   = (m_mode == 2 && txq.size() > 0) ? txq[0] : 8'h00;
    rd   = (rxq.size() > 0) ? rxq[0] : 8'h00;
    return {m_mode != 0, m_mode == 2, addr, {24'd0, wd}, resetn,
            resetn && (txq.size() < TX_DEPTH), rxq.size() > 0, rd, m_ovf, m_perr};
  endfunction

  always @(negedge clk) if (mdl_on) chk("model", {9'd0, dut_pack}, {9'd0, mdl_out()});

  // ---------------- directed vectors ----------------
  typedef struct {
    logic en, txv; logic [7:0] txd; logic rdy, rv; logic [31:0] rdat; logic rxr, clr;
    logic e_v, e_w; logic [7:0] e_addr, e_data; logic e_txr, e_rxv; logic [7:0] e_rxd;
    logic e_ovf, e_perr;
  } vec_t;

  vec_t tbl[13];

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    enable = 0; clear = 0; tx_in_valid = 0; tx_in_data = 0; rx_out_ready = 0;
    u_req_ready = 0; u_resp_valid = 0; u_resp_data = 0;
  endtask

  task automatic do_reset();
    resetn = 0; idle_inputs();
    repeat (2) cyc();
    resetn = 1;
  endtask

  logic [7:0] wr_seen[$];

  initial begin
    tbl[0]  = '{1,1,8'h41,1,0,32'h000,0,0, 0,0,8'h00,8'h00,1,0,8'h00,0,0};
    tbl[1]  = '{1,1,8'h42,1,0,32'h000,0,0, 1,0,8'h04,8'h00,1,0,8'h00,0,0};
    tbl[2]  = '{1,0,8'h00,1,1,32'h15A,0,0, 1,1,8'h00,8'h41,1,0,8'h00,0,0};
    tbl[3]  = '{1,0,8'h00,1,0,32'h000,0,0, 1,0,8'h04,8'h00,1,1,8'h5A,0,0};
    tbl[4]  = '{1,0,8'h00,1,1,32'h000,0,0, 1,1,8'h00,8'h42,1,1,8'h5A,0,0};
    tbl[5]  = '{1,0,8'h00,1,1,32'h177,0,0, 1,0,8'h04,8'h00,1,1,8'h5A,0,0};
    tbl[6]  = '{1,0,8'h00,1,1,32'h1A3,1,1, 1,0,8'h04,8'h00,1,1,8'h5A,0,1};
    tbl[7]  = '{0,0,8'h00,1,0,32'h000,0,0, 1,0,8'h04,8'h00,1,1,8'hA3,0,0};
    tbl[8]  = '{0,0,8'h00,1,1,32'h1B4,0,0, 0,0,8'h00,8'h00,1,1,8'hA3,0,0};
    tbl[9]  = '{0,0,8'h00,1,1,32'h000,0,1, 0,0,8'h00,8'h00,1,1,8'hA3,0,0};
    tbl[10] = '{0,0,8'h00,1,0,32'h000,1,0, 0,0,8'h00,8'h00,1,1,8'hA3,0,1};
    tbl[11] = '{0,0,8'h00,1,0,32'h000,1,0, 0,0,8'h00,8'h00,1,1,8'hB4,0,1};
    tbl[12] = '{0,0,8'h00,1,0,32'h000,0,0, 0,0,8'h00,8'h00,1,0,8'h00,0,1};

    // Reset with a pending TX byte and enable asserted
    resetn = 0; idle_inputs(); tx_in_valid = 1; tx_in_data = 8'h77; enable = 1;
    repeat (3) cyc();
    mdl_on = 1;
    @(negedge clk);
    chk("reset_values", {9'd0, dut_pack}, 64'd0);
    cyc();
    resetn = 1;

    for (int i = 0; i < 13; i++) begin
      enable = tbl[i].en; tx_in_valid = tbl[i].txv; tx_in_data = tbl[i].txd;
      u_req_ready = tbl[i].rdy; u_resp_valid = tbl[i].rv; u_resp_data = tbl[i].rdat;
      rx_out_ready = tbl[i].rxr; clear = tbl[i].clr;
      @(negedge clk);
      chk($sformatf("vector%0d", i), {9'd0, dut_pack},
          {9'd0, tbl[i].e_v, tbl[i].e_w, tbl[i].e_addr, 24'd0, tbl[i].e_data, 1'b1,
           tbl[i].e_txr, tbl[i].e_rxv, tbl[i].e_rxd, tbl[i].e_ovf, tbl[i].e_perr});
      cyc();
    end

    // RX overflow: RX_DEPTH+1 bytes with the client stalled
    do_reset();
    enable = 1;
    cyc(); cyc();
    for (int i = 0; i <= RX_DEPTH; i++) begin
      u_resp_valid = 1; u_resp_data = {23'd0, 1'b1, 8'h10 + 8'(i)};
      cyc();
    end
    u_resp_valid = 0; u_resp_data = 0;
    @(negedge clk);
    chk("ovf_set", {63'd0, rx_overflow}, 64'd1);
    cyc();
    rx_out_ready = 1;
    for (int i = 0; i < RX_DEPTH; i++) begin
      @(negedge clk);
      chk($sformatf("ovf_order%0d", i), {55'd0, rx_out_valid, rx_out_data},
          {55'd0, 1'b1, 8'h10 + 8'(i)});
      cyc();
    end
    rx_out_ready = 0;
    @(negedge clk);
    chk("ovf_drained", {63'd0, rx_out_valid}, 64'd0);
    cyc();
    clear = 1; cyc(); clear = 0;
    @(negedge clk);
    chk("ovf_cleared", {63'd0, rx_overflow}, 64'd0);
    cyc();

    // TX FIFO full with UART busy: polling and RX capture continue
    do_reset();
    enable = 1; u_req_ready = 0;
    for (int i = 0; i < TX_DEPTH; i++) begin
      tx_in_valid = 1; tx_in_data = 8'h80 + 8'(i);
      cyc();
    end
    tx_in_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("txfull_poll%0d", i), {53'd0, tx_in_ready, u_req_valid, u_req_write, u_req_addr},
          {53'd0, 1'b0, 1'b1, 1'b0, 8'h04});
      cyc();
    end
    u_resp_valid = 1; u_resp_data = 32'h199;
    cyc();
    u_resp_valid = 0; u_resp_data = 0; tx_in_valid = 0;
    @(negedge clk);
    chk("txfull_rx", {55'd0, rx_out_valid, rx_out_data}, {55'd0, 1'b1, 8'h99});
    cyc();
    u_req_ready = 1;
    wr_seen.delete();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (u_req_valid && u_req_write) wr_seen.push_back(u_req_data[7:0]);
      cyc();
    end
    chk("txfull_write_count", 64'(wr_seen.size()), 64'(TX_DEPTH));
    for (int i = 0; i < TX_DEPTH && i < wr_seen.size(); i++)
      chk($sformatf("txfull_write%0d", i), {56'd0, wr_seen[i]}, {56'd0, 8'h80 + 8'(i)});

    // Randomized traffic checked against the model every cycle
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      resetn       = ($urandom_range(0, 499) != 0);
      enable       = ($urandom_range(0, 19) != 0);
      tx_in_valid  = $urandom_range(0, 1);
      tx_in_data   = 8'($urandom);
      u_req_ready  = ($urandom_range(0, 3) != 0);
      u_resp_valid = ($urandom_range(0, 2) == 0);
      u_resp_data  = $urandom;
      rx_out_ready = ($urandom_range(0, 3) == 0);
      clear        = ($urandom_range(0, 30) == 0);
      cyc();
    end
    resetn = 1; idle_inputs();
    cyc();
    mdl_on = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
